// File: rtl/dot_product_seq_if.sv
// dot_product_seq_if: operand-in / result-out stream bundle for dot_product_seq.
// master = operand sequencer / result writer side, slave = the engine.
interface dot_product_seq_if #(
  parameter int DATA_W = 16,
  parameter int OUT_W  = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_a;
  logic [DATA_W-1:0] in_b;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [OUT_W-1:0]  out_data;
  logic              out_err;

  modport master (
    output in_valid, in_a, in_b, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_err
  );

  modport slave (
    input  in_valid, in_a, in_b, in_last, out_ready,
    output in_ready, out_valid, out_data, out_err
  );
endinterface

// File: rtl/dot_product_seq.sv
// dot_product_seq: sequential unsigned dot-product engine.
// Takes one (a,b) pair per transfer, accumulates up to LEN products at full
// precision in ACC_W bits, and hands one result per vector downstream.
// Optional macro DOT_PRODUCT_SAT_EN: saturate out_data instead of wrapping
// when the accumulator does not fit in OUT_W bits.
module dot_product_seq #(
  parameter int DATA_W = 16,
  parameter int LEN    = 3,
  parameter int OUT_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  dot_product_seq_if.slave     bus
);
  localparam int ACC_W = 2*DATA_W + $clog2(LEN+1);
  localparam int CNT_W = $clog2(LEN+1);

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  state_t             r_state;
  logic [ACC_W-1:0]   r_acc;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_in_ready;
  logic               r_out_valid;
  logic [OUT_W-1:0]   r_out_data;
  logic               r_out_err;

  logic               w_xfer;
  logic [ACC_W-1:0]   w_prod;
  logic [ACC_W-1:0]   w_acc_next;
  logic [CNT_W-1:0]   w_cnt_inc;
  logic               w_end;
  logic [OUT_W-1:0]   w_out;

  assign w_xfer = bus.in_valid & r_in_ready;
  assign w_prod = ACC_W'(bus.in_a) * ACC_W'(bus.in_b);

  // Next accumulator value: IDLE starts fresh, ACC adds onto the running sum.
  // r_cnt is always 0 in IDLE, so w_cnt_inc==LEN covers the LEN==1 case too.
  always_comb begin
    w_acc_next = w_prod;
    if (r_state == ACC) w_acc_next = r_acc + w_prod;
    w_cnt_inc  = r_cnt + CNT_W'(1);
    w_end      = bus.in_last | (w_cnt_inc == CNT_W'(LEN));
  end

  // Narrow the final accumulator to the output width.
  generate
    if (OUT_W >= ACC_W) begin : g_zext
      assign w_out = OUT_W'(w_acc_next);
    end else begin : g_narrow
`ifdef DOT_PRODUCT_SAT_EN
      assign w_out = (|w_acc_next[ACC_W-1:OUT_W]) ? {OUT_W{1'b1}}
                                                   : w_acc_next[OUT_W-1:0];
`else
      assign w_out = w_acc_next[OUT_W-1:0];
`endif
    end
  endgenerate

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE, ACC: begin
          r_in_ready <= 1'b1;
          if (w_xfer) begin
            r_acc <= w_acc_next;
            r_cnt <= w_cnt_inc;
            if (w_end) begin
              r_state     <= DONE;
              r_in_ready  <= 1'b0;
              r_out_valid <= 1'b1;
              r_out_data  <= w_out;
              // Ended by count with no in_last on the final pair.
              r_out_err   <= ~bus.in_last;
            end else begin
              r_state <= ACC;
            end
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_in_ready  <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_err   = r_out_err;
endmodule

// File: tb/tb_dot_product_seq.sv
// tb_dot_product_seq: directed bench for dot_product_seq at default parameters.
module tb_dot_product_seq;
  localparam int DATA_W = 16;
  localparam int LEN    = 3;
  localparam int OUT_W  = 16;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  dot_product_seq_if #(.DATA_W(DATA_W), .OUT_W(OUT_W)) bus ();

  dot_product_seq #(.DATA_W(DATA_W), .LEN(LEN), .OUT_W(OUT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // All driving and sampling happens 1 time unit after a rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one pair and wait (bounded) until it is accepted.
  task automatic send_pair(input logic [15:0] a, input logic [15:0] b, input logic last);
    bit done;
    done = 0;
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_last  = last;
    for (int i = 0; i < 20 && !done; i++) begin
      if (bus.in_ready === 1'b1) done = 1;
      step();
    end
    bus.in_valid = 1'b0;
    bus.in_a     = 16'hDEAD;
    bus.in_b     = 16'hBEEF;
    bus.in_last  = 1'b0;
    if (!done) begin
      n_vec++; n_err++;
      $display("FAIL send_timeout: in_ready=%b required 1 within 20 cycles", bus.in_ready);
    end
  endtask

  // Expect a result right now, check it, then hand it off.
  task automatic take_result(input string name, input logic [15:0] exp_d, input logic exp_e);
    n_vec++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== exp_d || bus.out_err !== exp_e) begin
      n_err++;
      $display("FAIL %s: valid=%b data=%h err=%b required valid=1 data=%h err=%b",
               name, bus.out_valid, bus.out_data, bus.out_err, exp_d, exp_e);
    end
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    n_vec++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL %s_handoff: valid=%b in_ready=%b required valid=0 in_ready=1",
               name, bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    n_vec++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 ||
        bus.out_data !== 16'h0 || bus.out_err !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state: in_ready=%b valid=%b data=%h err=%b required 0 0 0000 0",
               bus.in_ready, bus.out_valid, bus.out_data, bus.out_err);
    end
    rst = 1'b0;
    step();
    n_vec++;
    if (bus.in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_release: in_ready=%b required 1", bus.in_ready);
    end
  endtask

  task automatic test_basic();
    send_pair(16'd1, 16'd4, 1'b0);
    send_pair(16'd2, 16'd5, 1'b0);
    n_vec++;
    if (bus.out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL basic_early_valid: valid=%b required 0", bus.out_valid);
    end
    send_pair(16'd3, 16'd6, 1'b1);
    take_result("basic", 16'd32, 1'b0);
  endtask

  task automatic test_early_end();
    send_pair(16'd2, 16'd3, 1'b0);
    send_pair(16'd4, 16'd5, 1'b1);
    take_result("early_end", 16'd26, 1'b0);
    send_pair(16'd7, 16'd7, 1'b1);
    take_result("single_pair", 16'd49, 1'b0);
  endtask

  task automatic test_overrun();
    send_pair(16'd1, 16'd1, 1'b0);
    send_pair(16'd1, 16'd1, 1'b0);
    send_pair(16'd1, 16'd1, 1'b0);
    take_result("overrun", 16'd3, 1'b1);
    send_pair(16'd2, 16'd2, 1'b1);
    take_result("after_overrun", 16'd4, 1'b0);
  endtask

  task automatic test_overflow();
    send_pair(16'hFFFF, 16'hFFFF, 1'b1);
`ifdef DOT_PRODUCT_SAT_EN
    take_result("overflow_sat", 16'hFFFF, 1'b0);
`else
    take_result("overflow_wrap", 16'h0001, 1'b0);
`endif
  endtask

  task automatic test_bubbles();
    send_pair(16'd1, 16'd2, 1'b0);
    step(); step(); step();
    send_pair(16'd3, 16'd4, 1'b1);
    take_result("bubbles", 16'd14, 1'b0);
  endtask

  task automatic test_backpressure();
    send_pair(16'd3, 16'd4, 1'b1);
    bus.in_valid = 1'b1;
    bus.in_a     = 16'd100;
    bus.in_b     = 16'd100;
    bus.in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      n_vec++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 16'd12 || bus.in_ready !== 1'b0) begin
        n_err++;
        $display("FAIL backpressure_hold%0d: valid=%b data=%h in_ready=%b required 1 000c 0",
                 i, bus.out_valid, bus.out_data, bus.in_ready);
      end
      step();
    end
    bus.in_valid = 1'b0;
    take_result("backpressure", 16'd12, 1'b0);
    send_pair(16'd5, 16'd5, 1'b1);
    take_result("after_backpressure", 16'd25, 1'b0);
  endtask

  task automatic test_mid_reset();
    send_pair(16'd9, 16'd9, 1'b0);
    send_pair(16'd9, 16'd9, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_vec++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL mid_reset_state: valid=%b in_ready=%b required 0 0",
               bus.out_valid, bus.in_ready);
    end
    send_pair(16'd1, 16'd1, 1'b0);
    send_pair(16'd1, 16'd1, 1'b0);
    send_pair(16'd1, 16'd1, 1'b1);
    take_result("mid_reset", 16'd3, 1'b0);
  endtask

  task automatic test_reset_in_done();
    send_pair(16'd2, 16'd2, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_vec++;
    if (bus.out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_in_done: valid=%b required 0", bus.out_valid);
    end
    send_pair(16'd6, 16'd7, 1'b1);
    take_result("after_done_reset", 16'd42, 1'b0);
  endtask

  initial begin
    n_vec         = 0;
    n_err         = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    test_reset();
    test_basic();
    test_early_end();
    test_overrun();
    test_overflow();
    test_bubbles();
    test_backpressure();
    test_mid_reset();
    test_reset_in_done();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
